// File: rtl/cp0_regfile.sv
// cp0_regfile
// Coprocessor-0 register file for the OpenMIPS core. It answers the execute
// stage's mfc0 reads combinationally and commits mtc0 writes arriving from
// write-back. It also runs the free-running Count timer, samples the external
// interrupt lines into Cause, and raises a sticky timer interrupt when Count
// matches a non-zero Compare.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous reset, active high
//   we_i         write enable from write-back
//   waddr_i      CP0 register number to write
//   data_i       write data
//   raddr_i      CP0 register number to read (execute stage inst[15:11])
//   int_i        external hardware interrupt lines
//   data_o       read data for raddr_i (0 while rst, 0 when unimplemented)
//   count_o .. prid_o  current register values
//   timer_int_o  sticky timer interrupt
module cp0_regfile #(
    parameter logic [31:0] PRID_VAL   = 32'h004c0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000,
    parameter logic [31:0] STATUS_RST = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;
    localparam logic [4:0] ADDR_CONFIG  = 5'd16;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_timer_int;

    logic        w_match;
    logic [31:0] w_rdata;

    // Match uses the pre-edge register values, so a Count write on the
    // same edge does not affect this edge's match decision.
    assign w_match = (r_compare != 32'd0) && (r_count == r_compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_status    <= STATUS_RST;
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_timer_int <= 1'b0;
        end else begin
            r_count         <= r_count + 32'd1;
            r_cause[15:10]  <= int_i;
            if (w_match) begin
                r_timer_int <= 1'b1;
            end
            // Later assignments below take priority over the free-running
            // updates above (Count write beats increment, Compare write
            // clears a same-edge match).
            if (we_i) begin
                case (waddr_i)
                    ADDR_COUNT: r_count <= data_i;
                    ADDR_COMPARE: begin
                        r_compare   <= data_i;
                        r_timer_int <= 1'b0;
                    end
                    ADDR_STATUS: r_status <= data_i;
                    ADDR_CAUSE: begin
                        // Only IP1..0, WP and IV are software writable.
                        r_cause[9:8]   <= data_i[9:8];
                        r_cause[23:22] <= data_i[23:22];
                    end
                    ADDR_EPC: r_epc <= data_i;
                    default: ;
                endcase
            end
        end
    end

    // No write-through: a write on this cycle shows up only after the edge.
    always_comb begin
        w_rdata = 32'd0;
        if (!rst) begin
            case (raddr_i)
                ADDR_COUNT:   w_rdata = r_count;
                ADDR_COMPARE: w_rdata = r_compare;
                ADDR_STATUS:  w_rdata = r_status;
                ADDR_CAUSE:   w_rdata = r_cause;
                ADDR_EPC:     w_rdata = r_epc;
                ADDR_PRID:    w_rdata = PRID_VAL;
                ADDR_CONFIG:  w_rdata = CONFIG_VAL;
                default:      w_rdata = 32'd0;
            endcase
        end
    end

    assign data_o      = w_rdata;
    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign config_o    = CONFIG_VAL;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'd0;
    logic [31:0] data_i = 32'd0;
    logic [4:0]  raddr_i = 5'd0;
    logic [5:0]  int_i = 6'd0;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .int_i(int_i), .data_o(data_o), .count_o(count_o),
        .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
        .timer_int_o(timer_int_o)
    );

    // Reference model: architectural register values.
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_tint;
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    always @(posedge clk) begin
        logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
        logic        n_tint;
        if (rst) begin
            n_count = 0; n_compare = 0; n_status = 32'h10000000;
            n_cause = 0; n_epc = 0; n_tint = 1'b0;
        end else begin
            n_count   = m_count + 1;
            n_compare = m_compare;
            n_status  = m_status;
            n_epc     = m_epc;
            n_cause   = {m_cause[31:16], int_i, m_cause[9:0]};
            n_tint    = m_tint || (m_compare != 0 && m_count == m_compare);
            if (we_i) begin
                if (waddr_i == 9)  n_count = data_i;
                if (waddr_i == 11) begin n_compare = data_i; n_tint = 1'b0; end
                if (waddr_i == 12) n_status = data_i;
                if (waddr_i == 13) n_cause = (n_cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
                if (waddr_i == 14) n_epc = data_i;
            end
        end
        m_count <= n_count; m_compare <= n_compare; m_status <= n_status;
        m_cause <= n_cause; m_epc <= n_epc; m_tint <= n_tint;
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst) return 32'd0;
        case (a)
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h004c0102;
            5'd16: return 32'h00008000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_o",    data_o,    exp_rd(raddr_i));
            chk("count_o",   count_o,   m_count);
            chk("compare_o", compare_o, m_compare);
            chk("status_o",  status_o,  m_status);
            chk("cause_o",   cause_o,   m_cause);
            chk("epc_o",     epc_o,     m_epc);
            chk("config_o",  config_o,  32'h00008000);
            chk("prid_o",    prid_o,    32'h004c0102);
            chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        cyc();
        we_i = 1'b0;
    endtask

    initial begin
        logic [4:0]  raddrs [7];
        logic [31:0] rvals  [7];
        raddrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
        rvals  = '{32'h0, 32'h0, 32'h10000000, 32'h0, 32'h0, 32'h004c0102, 32'h00008000};

        // 1. reset
        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            raddr_i = raddrs[i];
            #1;
            chk("rst_read", data_o, rvals[i]);
        end
        chk("rst_timer", {31'd0, timer_int_o}, 32'd0);
        cyc();
        chk("count_first", count_o, 32'd1);

        // 2. count write and wrap
        raddr_i = 5'd9;
        wr(5'd9, 32'hFFFFFFFE);
        chk("wrap0", data_o, 32'hFFFFFFFE);
        cyc(); chk("wrap1", data_o, 32'hFFFFFFFF);
        cyc(); chk("wrap2", data_o, 32'h00000000);

        // 3. timer match
        wr(5'd11, 32'h20);
        wr(5'd9, 32'h1E);
        chk("tm_c1e", count_o, 32'h1E); chk("tm_i1e", {31'd0, timer_int_o}, 32'd0);
        cyc(); chk("tm_c1f", count_o, 32'h1F); chk("tm_i1f", {31'd0, timer_int_o}, 32'd0);
        cyc(); chk("tm_c20", count_o, 32'h20); chk("tm_i20", {31'd0, timer_int_o}, 32'd0);
        cyc(); chk("tm_c21", count_o, 32'h21); chk("tm_i21", {31'd0, timer_int_o}, 32'd1);
        cyc(); chk("tm_hold", {31'd0, timer_int_o}, 32'd1);
        wr(5'd11, 32'h40);
        chk("tm_clear", {31'd0, timer_int_o}, 32'd0);

        // 4. cause mask, read-only registers
        int_i = 6'b101010;
        wr(5'd13, 32'hFFFFFFFF);
        chk("cause_mask", cause_o, 32'h00C0AB00);
        wr(5'd15, 32'h0);
        wr(5'd16, 32'h0);
        raddr_i = 5'd15; #1; chk("prid_ro", data_o, 32'h004c0102);
        raddr_i = 5'd16; #1; chk("config_ro", data_o, 32'h00008000);

        // 5. unimplemented read, no write-through
        raddr_i = 5'd3; #1; chk("unimpl", data_o, 32'h0);
        raddr_i = 5'd14;
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h80001234;
        #1; chk("no_bypass", data_o, 32'h0);
        cyc(); we_i = 1'b0;
        chk("epc_next", data_o, 32'h80001234);

        // 6. reset beats a same-edge write
        rst = 1'b1; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFFFFFF;
        cyc();
        rst = 1'b0; we_i = 1'b0;
        chk("rstpri_status", status_o, 32'h10000000);
        chk("rstpri_count", count_o, 32'h0);

        // Random phase, steered toward timer matches via the model's count.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] a;
            int sel;
            rst     = ($urandom_range(0, 199) == 0);
            int_i   = 6'($urandom);
            raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(9 + $urandom_range(0, 7));
            we_i    = $urandom_range(0, 1) == 1;
            sel     = $urandom_range(0, 9);
            a       = (sel == 9) ? 5'($urandom) : ((sel == 8) ? 5'd9 : 5'(9 + sel));
            waddr_i = a;
            data_i  = $urandom;
            if (a == 5'd11 && $urandom_range(0, 1) == 1)
                data_i = m_count + 32'($urandom_range(0, 6));
            if (a == 5'd9 && $urandom_range(0, 1) == 1)
                data_i = m_compare - 32'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) data_i = 32'd0;
            cyc();
        end
        rst = 1'b0; we_i = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
